// File: rtl/decimal_entry.sv
// Two-digit decimal entry: tens then ones digit on key edges, converted to a binary position
// by repeated +10, range-checked, then offered on a valid/ready handshake.
// Optional echo of entry progress for the display: define DECIMAL_ENTRY_ECHO_EN.
module decimal_entry #(
    parameter int POS_WIDTH = 6,
    parameter int MAX_VALUE = 63
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           digit_in,
    input  logic                 key_in,
    input  logic                 cancel,
    input  logic                 pos_ready,
    output logic [POS_WIDTH-1:0] position,
    output logic                 pos_valid,
    output logic                 err,
    output logic                 busy,
    output logic [POS_WIDTH-1:0] echo_value
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GOT_TENS = 3'd1;
    localparam logic [2:0] S_CONVERT  = 3'd2;
    localparam logic [2:0] S_CHECK    = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;

    localparam logic [6:0] MAX_ACC = 7'(MAX_VALUE);

    logic [2:0]           state_q, state_d;
    logic                 key_q;
    logic [3:0]           tens_q, tens_d;
    logic [6:0]           acc_q, acc_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [POS_WIDTH-1:0] position_q, position_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 busy_q;
    logic                 key_edge;
    logic                 digit_bad;

    assign key_edge  = key_in & ~key_q;
    assign digit_bad = (digit_in > 4'd9);

    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        position_d = position_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        if (cancel) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_edge) begin
                        if (digit_bad) begin
                            err_d = 1'b1;
                        end else begin
                            tens_d  = digit_in;
                            state_d = S_GOT_TENS;
                        end
                    end
                end
                S_GOT_TENS: begin
                    if (key_edge) begin
                        if (digit_bad) begin
                            err_d = 1'b1;
                        end else begin
                            acc_d   = {3'b000, digit_in};
                            cnt_d   = tens_q;
                            state_d = S_CONVERT;
                        end
                    end
                end
                S_CONVERT: begin
                    if (cnt_q != 4'd0) begin
                        acc_d = acc_q + 7'd10;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (acc_q > MAX_ACC) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        position_d = acc_q[POS_WIDTH-1:0];
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (pos_ready) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            key_q      <= 1'b1;   // a key held through reset must not register as a press
            tens_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            position_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_in;
            tens_q     <= tens_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            position_q <= position_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign position  = position_q;
    assign pos_valid = valid_q;
    assign err       = err_q;
    assign busy      = busy_q;

`ifdef DECIMAL_ENTRY_ECHO_EN
    localparam logic [6:0] SAT = 7'((1 << POS_WIDTH) - 1);
    logic [6:0] echo_raw;

    always_comb begin
        case (state_q)
            S_GOT_TENS:        echo_raw = {3'b000, tens_q} * 7'd10;
            S_CONVERT, S_CHECK: echo_raw = acc_q;
            default:           echo_raw = 7'(position_q);
        endcase
    end

    // Saturate so a partial value wider than the output never wraps on the display.
    assign echo_value = (echo_raw > SAT) ? SAT[POS_WIDTH-1:0] : echo_raw[POS_WIDTH-1:0];
`else
    assign echo_value = '0;
`endif

endmodule

// File: tb/tb_decimal_entry.sv
// Self-checking bench for decimal_entry: hand sequences for reset, errors and cancel,
// a vector table of entries, then random entries against an arithmetic model.
module tb_decimal_entry;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit_in;
    logic       key_in;
    logic       cancel;
    logic       pos_ready;
    logic [5:0] position;
    logic       pos_valid;
    logic       err;
    logic       busy;
    logic [5:0] echo_value;

    int errors = 0;
    int checks = 0;

    decimal_entry #(.POS_WIDTH(6), .MAX_VALUE(63)) dut (
        .clk(clk), .reset(reset), .digit_in(digit_in), .key_in(key_in),
        .cancel(cancel), .pos_ready(pos_ready), .position(position),
        .pos_valid(pos_valid), .err(err), .busy(busy), .echo_value(echo_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tens;
        int ones;
        bit exp_err;
        int exp_pos;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_echo(input int v);
`ifdef DECIMAL_ENTRY_ECHO_EN
        return (v > 63) ? 63 : v;
`else
        return 0 * v;
`endif
    endfunction

    // Returns just after the clock edge that sampled the press.
    task automatic press(input int d);
        key_in = 1'b0;
        tick();
        digit_in = 4'(d);
        key_in   = 1'b1;
        tick();
        key_in = 1'b0;
    endtask

    task automatic finish_entry(input int t, input int o, input bit exp_err,
                                input int exp_pos, input string nm);
        press(o);
        repeat (t + 1) tick();
        chk({nm, " valid_early"}, pos_valid, 0);
        chk({nm, " err_early"}, err, 0);
        tick();
        if (exp_err) begin
            chk({nm, " err"}, err, 1);
            chk({nm, " no_valid"}, pos_valid, 0);
            chk({nm, " idle"}, busy, 0);
            tick();
            chk({nm, " err_pulse"}, err, 0);
            chk({nm, " still_no_valid"}, pos_valid, 0);
        end else begin
            chk({nm, " valid"}, pos_valid, 1);
            chk({nm, " position"}, position, exp_pos);
            chk({nm, " echo_hold"}, echo_value, exp_echo(exp_pos));
            repeat (2) tick();
            chk({nm, " valid_held"}, pos_valid, 1);
            chk({nm, " position_held"}, position, exp_pos);
            pos_ready = 1'b1;
            tick();
            pos_ready = 1'b0;
            chk({nm, " valid_dropped"}, pos_valid, 0);
            chk({nm, " idle_after"}, busy, 0);
        end
    endtask

    task automatic entry(input int t, input int o, input bit exp_err,
                         input int exp_pos, input string nm);
        press(t);
        chk({nm, " busy_tens"}, busy, 1);
        if (t * 10 <= 63) chk({nm, " echo_tens"}, echo_value, exp_echo(t * 10));
        finish_entry(t, o, exp_err, exp_pos, nm);
    endtask

    initial begin
        vecs[0] = '{tens: 4, ones: 2, exp_err: 1'b0, exp_pos: 42};
        vecs[1] = '{tens: 0, ones: 7, exp_err: 1'b0, exp_pos: 7};
        vecs[2] = '{tens: 6, ones: 3, exp_err: 1'b0, exp_pos: 63};
        vecs[3] = '{tens: 6, ones: 4, exp_err: 1'b1, exp_pos: 0};
        vecs[4] = '{tens: 9, ones: 9, exp_err: 1'b1, exp_pos: 0};
        vecs[5] = '{tens: 0, ones: 0, exp_err: 1'b0, exp_pos: 0};
        vecs[6] = '{tens: 5, ones: 9, exp_err: 1'b0, exp_pos: 59};
        vecs[7] = '{tens: 7, ones: 0, exp_err: 1'b1, exp_pos: 0};

        reset = 1'b1; key_in = 1'b1; digit_in = 4'd4; cancel = 1'b0; pos_ready = 1'b0;
        repeat (3) tick();
        chk("reset position", position, 0);
        chk("reset valid", pos_valid, 0);
        chk("reset err", err, 0);
        chk("reset busy", busy, 0);
        chk("reset echo", echo_value, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("held key no action", busy, 0);
        chk("held key no err", err, 0);

        // First press of 4 then 2: 6-cycle latency, hold, release with pos_ready.
        entry(4, 2, 1'b0, 42, "seq42");
        $display("txn seq42 done position=%0d", position);

        // Cancel during CONVERT keeps the previously accepted position.
        press(9);
        press(1);
        repeat (3) tick();
        chk("cancel busy_convert", busy, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel idle", busy, 0);
        chk("cancel no_err", err, 0);
        chk("cancel no_valid", pos_valid, 0);
        chk("cancel keeps_position", position, 42);
        repeat (12) tick();
        chk("cancel no_late_valid", pos_valid, 0);
        chk("cancel no_late_err", err, 0);
        $display("txn cancel_convert done");

        // Cancel and key edge together: cancel wins.
        press(5);
        key_in = 1'b0;
        tick();
        digit_in = 4'd3; key_in = 1'b1; cancel = 1'b1;
        tick();
        key_in = 1'b0; cancel = 1'b0;
        chk("cancel_vs_key idle", busy, 0);
        chk("cancel_vs_key no_err", err, 0);
        repeat (10) tick();
        chk("cancel_vs_key no_valid", pos_valid, 0);
        $display("txn cancel_vs_key done");

        // Bad digit in IDLE, then bad digit in GOT_TENS keeps the tens digit.
        press(12);
        chk("bad_idle err", err, 1);
        chk("bad_idle stays", busy, 0);
        tick();
        chk("bad_idle err_pulse", err, 0);
        press(3);
        chk("tens3 echo", echo_value, exp_echo(30));
        press(11);
        chk("bad_tens err", err, 1);
        chk("bad_tens busy", busy, 1);
        tick();
        chk("bad_tens err_pulse", err, 0);
        chk("bad_tens echo_kept", echo_value, exp_echo(30));
        finish_entry(3, 5, 1'b0, 35, "after_bad");
        $display("txn bad_digits done position=%0d", position);

        // pos_ready held high: exactly one valid cycle.
        pos_ready = 1'b1;
        press(1);
        press(2);
        repeat (3) tick();
        chk("ready_held valid", pos_valid, 1);
        chk("ready_held position", position, 12);
        tick();
        chk("ready_held one_cycle", pos_valid, 0);
        chk("ready_held idle", busy, 0);
        pos_ready = 1'b0;
        $display("txn ready_held done");

        foreach (vecs[i]) begin
            entry(vecs[i].tens, vecs[i].ones, vecs[i].exp_err, vecs[i].exp_pos,
                  $sformatf("vec%0d", i));
            $display("txn vec%0d tens=%0d ones=%0d err=%0b pos=%0d", i,
                     vecs[i].tens, vecs[i].ones, vecs[i].exp_err, position);
        end

        for (int n = 0; n < 25; n++) begin
            int t;
            int o;
            int val;
            t   = $urandom_range(0, 9);
            o   = $urandom_range(0, 9);
            val = t * 10 + o;
            entry(t, o, (val > 63), (val > 63) ? 0 : val, $sformatf("rnd%0d", n));
            $display("txn rnd%0d tens=%0d ones=%0d model=%0d", n, t, o, val);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
